// File: rtl/reg_fifo.sv
// rtl/reg_fifo.sv - register-based first-word-fall-through FIFO
module reg_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           Din,
    input  logic                       wr_en,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           Qout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf,
    output logic                       unf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, unf_q;
    logic             push, pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;
    assign Qout  = empty ? '0 : mem_q[rp_q];

    // A pop frees the head slot in the same edge, so a full FIFO may still push.
    assign push = wr_en && (!full || rd_en);
    assign pop  = rd_en && !empty;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wp_q] <= Din;
                wp_q        <= wp_q + 1'b1;
            end
            if (pop) begin
                rp_q <= rp_q + 1'b1;
            end
            count_q <= count_d;
            ovf_q   <= wr_en && !push;
            unf_q   <= rd_en && !pop;
        end
    end

endmodule

// File: tb/tb_reg_fifo.sv
// tb/tb_reg_fifo.sv - self-checking bench for reg_fifo against a queue model
module tb_reg_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] Din = '0;
    logic             wr_en = 1'b0;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] Qout;
    logic             full, empty, ovf, unf;
    logic [2:0]       count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] mq[$];
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

    reg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .clr   (clr),
        .Din   (Din),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .Qout  (Qout),
        .full  (full),
        .empty (empty),
        .count (count),
        .ovf   (ovf),
        .unf   (unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [WIDTH-1:0] head;
        head = (mq.size() > 0) ? mq[0] : '0;
        chk("count", 32'(count), 32'(mq.size()));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full",  32'(full),  32'(mq.size() == DEPTH));
        chk("Qout",  32'(Qout),  32'(head));
        chk("ovf",   32'(ovf),   32'(m_ovf));
        chk("unf",   32'(unf),   32'(m_unf));
    endtask

    // Apply one cycle of inputs, advance the model, then compare away from the edge.
    task automatic step(input logic c, input logic w, input logic r, input logic [WIDTH-1:0] d);
        bit push_ok, pop_ok;
        clr = c; wr_en = w; rd_en = r; Din = d;
        @(posedge clk);
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            push_ok = w && ((mq.size() < DEPTH) || r);
            pop_ok  = r && (mq.size() > 0);
            if (pop_ok)  void'(mq.pop_front());
            if (push_ok) mq.push_back(d);
            m_ovf = w && !push_ok;
            m_unf = r && !pop_ok;
        end
        #1;
        clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        check_model();
    endtask

    initial begin
        logic [WIDTH-1:0] seq [4];

        // Reset with both requests high
        step(1, 1, 1, 8'hFF);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_qout", 32'(Qout), 32'h00);
        chk("rst_empty", 32'(empty), 32'd1);

        // Fill and overflow
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
        for (int i = 0; i < 4; i++) step(0, 1, 0, seq[i]);
        step(0, 1, 0, 8'h55);
        chk("ovf_pulse", 32'(ovf), 32'd1);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_head", 32'(Qout), 32'h11);
        step(0, 0, 0, 8'h00);
        chk("ovf_clear", 32'(ovf), 32'd0);

        // Drain and underflow
        for (int i = 0; i < 4; i++) begin
            chk("drain_head", 32'(Qout), 32'(seq[i]));
            step(0, 0, 1, 8'h00);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        step(0, 0, 1, 8'h00);
        chk("unf_pulse", 32'(unf), 32'd1);
        chk("unf_qout", 32'(Qout), 32'h00);

        // Pointer wrap
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'($urandom));
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h00);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'(8'hA0 + i));
        for (int i = 0; i < 4; i++) begin
            chk("wrap_head", 32'(Qout), 32'(8'hA0 + i));
            step(0, 0, 1, 8'h00);
        end
        chk("wrap_count", 32'(count), 32'd0);

        // Simultaneous push/pop when full, then when empty
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'(8'hC0 + i));
        step(0, 1, 1, 8'h99);
        chk("sim_full_count", 32'(count), 32'd4);
        chk("sim_full_head", 32'(Qout), 32'hC1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h00);
        chk("sim_99_fourth", 32'(Qout), 32'h99);
        step(0, 0, 1, 8'h00);
        step(0, 1, 1, 8'h5A);
        chk("sim_empty_count", 32'(count), 32'd1);
        chk("sim_empty_qout", 32'(Qout), 32'h5A);
        chk("sim_empty_unf", 32'(unf), 32'd1);
        step(0, 0, 1, 8'h00);

        // Mid-operation reset
        step(0, 1, 0, 8'h01);
        step(0, 1, 0, 8'h02);
        step(1, 1, 1, 8'h03);
        chk("mid_empty", 32'(empty), 32'd1);
        chk("mid_qout", 32'(Qout), 32'h00);
        step(0, 1, 0, 8'h7E);
        chk("mid_push_qout", 32'(Qout), 32'h7E);
        chk("mid_push_count", 32'(count), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_fifo.md
REG_FIFO -- requirements
Module: reg_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits (WIDTH >= 1).
REQ-002 SHALL have parameter DEPTH, default 8, number of storage entries (power of two, DEPTH >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port clr  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port Din  input  WIDTH  write data.
REQ-006 SHALL have port wr_en  input  1  push request.
REQ-007 SHALL have port rd_en  input  1  pop request.
REQ-008 SHALL have port Qout  output  WIDTH  head-of-queue data (first-word-fall-through).
REQ-009 SHALL have port full  output  1  high when count == DEPTH.
REQ-010 SHALL have port empty  output  1  high when count == 0.
REQ-011 SHALL have port count  output  log2(DEPTH)+1  number of valid entries, 0..DEPTH.
REQ-012 SHALL have port ovf  output  1  one-cycle pulse: rejected push.
REQ-013 SHALL have port unf  output  1  one-cycle pulse: rejected pop.

Function
REQ-014 SHALL store entries in a DEPTH x WIDTH array indexed by write pointer wp and read pointer rp, each log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-015 SHALL accept a push iff wr_en && (!full || rd_en); accepted push writes Din to entry wp and increments wp.
REQ-016 SHALL accept a pop iff rd_en && !empty; accepted pop increments rp.
REQ-017 SHALL, when full with wr_en and rd_en both high, accept both; count stays DEPTH, full stays high.
REQ-018 SHALL, when empty with wr_en and rd_en both high, accept the push only; count becomes 1, unf pulses.
REQ-019 SHALL update count next cycle as count + push - pop (accepted operations only); count never exceeds DEPTH nor goes below 0.
REQ-020 SHALL drive Qout combinationally from entry rp when !empty, and all-zero when empty.
REQ-021 SHALL make a pushed word visible on Qout the cycle after the push edge (latency 1 cycle, FWFT).
REQ-022 SHALL derive full and empty combinationally from registered count.
REQ-023 SHALL assert ovf for exactly the cycle after an edge where wr_en was high and the push was rejected; otherwise 0.
REQ-024 SHALL assert unf for exactly the cycle after an edge where rd_en was high and the pop was rejected; otherwise 0.
REQ-025 SHALL leave storage, pointers and count unchanged when neither wr_en nor rd_en is high.
REQ-026 SHALL keep data order strictly first-in first-out across pointer wrap-around.

Reset
REQ-027 SHALL, on a rising clk edge with clr high, set wp=0, rp=0, count=0, ovf=0, unf=0 and all storage entries to 0.
REQ-028 SHALL give clr priority over wr_en and rd_en in the same cycle; no push or pop is accepted.
REQ-029 SHALL present after reset: Qout=0, empty=1, full=0, count=0.
REQ-030 SHALL discard all queued data when clr asserts mid-operation; first push after reset lands in entry 0.

Verification (WIDTH=8, DEPTH=4)
REQ-031 Reset: clr high 1 cycle with wr_en=rd_en=1 -> count=0, empty=1, Qout=0x00, ovf=unf=0.
REQ-032 Fill/overflow: push 0x11,0x22,0x33,0x44, then push 0x55 -> full=1, count=4, ovf pulses 1 cycle, Qout=0x11.
REQ-033 Drain/underflow: pop 4 times from REQ-032 state -> Qout sequence 0x11,0x22,0x33,0x44, then empty=1; fifth pop -> unf pulses, Qout=0x00.
REQ-034 Wrap: push 3, pop 3, push 0xA0..0xA3, pop 4 -> output 0xA0,0xA1,0xA2,0xA3 in order, count returns to 0.
REQ-035 Simultaneous: full with wr_en=rd_en=1, Din=0x99 -> count stays 4, head advances, 0x99 emerges fourth; empty with both high -> count=1, Qout=Din next cycle, unf pulses.
REQ-036 Mid-op reset: count=2, clr pulse -> empty=1, Qout=0x00; next push 0x7E -> Qout=0x7E, count=1.
